// File: rtl/button_input_handler_pkg.sv
// Shared types and constants for the pushbutton front end.
// Cursor one-hot codes, button indices, auto-repeat FSM states and default cycle counts.
package button_input_handler_pkg;

    localparam logic [2:0] CURSOR_SEC  = 3'b001;
    localparam logic [2:0] CURSOR_MIN  = 3'b010;
    localparam logic [2:0] CURSOR_HOUR = 3'b100;

    localparam int NUM_BTNS  = 5;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_RST   = 4;

    localparam int DEF_DEBOUNCE_CYCLES      = 2_000_000;
    localparam int DEF_REPEAT_DELAY_CYCLES  = 50_000_000;
    localparam int DEF_REPEAT_PERIOD_CYCLES = 10_000_000;
    localparam int REPEAT_CNT_W             = 26;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    function automatic logic [2:0] cursor_toward_hours(input logic [2:0] c);
        return {c[1:0], c[2]};
    endfunction

    function automatic logic [2:0] cursor_toward_seconds(input logic [2:0] c);
        return {c[0], c[2:1]};
    endfunction

endpackage

// File: rtl/button_input_handler_button_debouncer.sv
// One pushbutton: two-flop synchronizer, stability counter and a registered press event.
// level_o is the debounced level delayed so that it lines up with press_o.
module button_debouncer
    import button_input_handler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n_i,
    output logic press_o,
    output logic level_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             state_q, state_d;
    logic             prev_q, press_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed_s;

    assign pressed_s = ~sync2_q;

    // Stability counter: any sample that agrees with the debounced state restarts the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (pressed_s == state_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            state_d = ~state_q;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchronizer, debounced state and press-event registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= state_q;
            press_q <= state_q & ~prev_q;
        end
    end

    assign press_o = press_q;
    assign level_o = prev_q;

endmodule

// File: rtl/button_input_handler.sv
// Pushbutton front end: debounced buttons to up/down/clock_reset pulses and a one-hot cursor.
// Optional up/down auto-repeat is compiled in with BUTTON_AUTO_REPEAT_EN.
module button_input_handler
    import button_input_handler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up_n,
    input  logic       btn_down_n,
    input  logic       btn_left_n,
    input  logic       btn_right_n,
    input  logic       btn_rst_n,
    output logic       up,
    output logic       down,
    output logic       clock_reset,
    output logic [2:0] cursor_pos
);

    logic [NUM_BTNS-1:0] btn_n_s, press_s, level_s;

    assign btn_n_s[BTN_UP]    = btn_up_n;
    assign btn_n_s[BTN_DOWN]  = btn_down_n;
    assign btn_n_s[BTN_LEFT]  = btn_left_n;
    assign btn_n_s[BTN_RIGHT] = btn_right_n;
    assign btn_n_s[BTN_RST]   = btn_rst_n;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk     (clk),
            .reset   (reset),
            .btn_n_i (btn_n_s[i]),
            .press_o (press_s[i]),
            .level_o (level_s[i])
        );
    end

    logic       up_cmd_s, down_cmd_s, rst_ev_s;
    logic [2:0] cursor_d, cursor_q;
    logic       up_q, down_q, clock_reset_q;

    // Command decode; a reset press wins over any cursor move in the same cycle.
    always_comb begin
        up_cmd_s   = press_s[BTN_UP] & ~press_s[BTN_DOWN];
        down_cmd_s = press_s[BTN_DOWN] & ~press_s[BTN_UP];
        rst_ev_s   = press_s[BTN_RST];
        if (rst_ev_s) begin
            cursor_d = CURSOR_SEC;
        end else if (press_s[BTN_LEFT] & ~press_s[BTN_RIGHT]) begin
            cursor_d = cursor_toward_hours(cursor_q);
        end else if (press_s[BTN_RIGHT] & ~press_s[BTN_LEFT]) begin
            cursor_d = cursor_toward_seconds(cursor_q);
        end else begin
            cursor_d = cursor_q;
        end
    end

    // Cursor and clock_reset output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cursor_q      <= CURSOR_SEC;
            clock_reset_q <= 1'b0;
        end else begin
            cursor_q      <= cursor_d;
            clock_reset_q <= rst_ev_s;
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [REPEAT_CNT_W-1:0] RPT_DELAY_LAST  = REPEAT_CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [REPEAT_CNT_W-1:0] RPT_PERIOD_LAST = REPEAT_CNT_W'(REPEAT_PERIOD_CYCLES - 1);

    rpt_state_e              rpt_state_q;
    logic [REPEAT_CNT_W-1:0] rpt_cnt_q, rpt_limit_s;
    logic                    rpt_key_up_q, rpt_cancel_s;
    logic                    unused_lvl_s;

    assign unused_lvl_s = ^{level_s[BTN_RST], level_s[BTN_RIGHT], level_s[BTN_LEFT]};

    // Repeat is abandoned on release of the latched key, a press of the other key, or clock reset.
    always_comb begin
        rpt_limit_s = (rpt_state_q == RPT_DELAY) ? RPT_DELAY_LAST : RPT_PERIOD_LAST;
        if (rpt_key_up_q) begin
            rpt_cancel_s = rst_ev_s | ~level_s[BTN_UP] | press_s[BTN_DOWN];
        end else begin
            rpt_cancel_s = rst_ev_s | ~level_s[BTN_DOWN] | press_s[BTN_UP];
        end
    end

    // Auto-repeat FSM with registered up/down pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_state_q  <= RPT_IDLE;
            rpt_cnt_q    <= {REPEAT_CNT_W{1'b0}};
            rpt_key_up_q <= 1'b0;
            up_q         <= 1'b0;
            down_q       <= 1'b0;
        end else begin
            up_q   <= up_cmd_s;
            down_q <= down_cmd_s;
            case (rpt_state_q)
                RPT_IDLE: begin
                    if (up_cmd_s | down_cmd_s) begin
                        rpt_state_q  <= RPT_DELAY;
                        rpt_cnt_q    <= {REPEAT_CNT_W{1'b0}};
                        rpt_key_up_q <= up_cmd_s;
                    end
                end
                RPT_DELAY, RPT_REPEAT: begin
                    if (rpt_cancel_s) begin
                        rpt_state_q <= RPT_IDLE;
                        rpt_cnt_q   <= {REPEAT_CNT_W{1'b0}};
                    end else if (rpt_cnt_q == rpt_limit_s) begin
                        rpt_state_q <= RPT_REPEAT;
                        rpt_cnt_q   <= {REPEAT_CNT_W{1'b0}};
                        if (rpt_key_up_q) begin
                            up_q <= 1'b1;
                        end else begin
                            down_q <= 1'b1;
                        end
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + REPEAT_CNT_W'(1);
                    end
                end
                default: begin
                    rpt_state_q <= RPT_IDLE;
                    rpt_cnt_q   <= {REPEAT_CNT_W{1'b0}};
                end
            endcase
        end
    end
`else
    localparam int unused_rpt_cfg = REPEAT_DELAY_CYCLES + REPEAT_PERIOD_CYCLES;

    logic unused_lvl_s;

    assign unused_lvl_s = ^level_s;

    // One up/down pulse per press event.
    always_ff @(posedge clk) begin
        if (reset) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
        end else begin
            up_q   <= up_cmd_s;
            down_q <= down_cmd_s;
        end
    end
`endif

    assign up          = up_q;
    assign down        = down_q;
    assign clock_reset = clock_reset_q;
    assign cursor_pos  = cursor_q;

endmodule

// File: tb/tb_button_input_handler.sv
// Self-checking bench for button_input_handler: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized button activity.
`timescale 1ns/1ps
module tb_button_input_handler;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int NB = 5;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] btn_n = 5'b11111;
    logic       up, down, clock_reset;
    logic [2:0] cursor_pos;

    always #5 clk = ~clk;

    button_input_handler #(
        .DEBOUNCE_CYCLES      (D),
        .REPEAT_DELAY_CYCLES  (RD),
        .REPEAT_PERIOD_CYCLES (RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_up_n    (btn_n[0]),
        .btn_down_n  (btn_n[1]),
        .btn_left_n  (btn_n[2]),
        .btn_right_n (btn_n[3]),
        .btn_rst_n   (btn_n[4]),
        .up          (up),
        .down        (down),
        .clock_reset (clock_reset),
        .cursor_pos  (cursor_pos)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int up_edges[$];
    int dn_edges[$];
    int rst_edges[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state: raw sample delay, debounced level per button, and its history as seen by the command logic.
    bit       smp [NB][2];
    bit       lvl [NB];
    int       run [NB];
    bit [2:0] lvh [NB];
    bit       ev  [NB];
    bit       held[NB];
    int       cur_idx;
    bit       e_up, e_dn, e_rst;
    logic [2:0] e_cur;
    logic       in_r;
    logic [4:0] in_b;
    bit         eff;
`ifdef BUTTON_AUTO_REPEAT_EN
    bit rep_act, rep_key_up, cancel;
    int rep_k;
`endif

    // Reference model and per-cycle compare.
    always begin
        @(posedge clk);
        cyc++;
        in_r = reset;
        in_b = btn_n;
        if (in_r) begin
            for (int b = 0; b < NB; b++) begin
                smp[b][0] = 1'b1;
                smp[b][1] = 1'b1;
                lvl[b]    = 1'b0;
                run[b]    = 0;
                lvh[b]    = 3'b000;
            end
            cur_idx = 0;
            e_up = 1'b0; e_dn = 1'b0; e_rst = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            rep_act = 1'b0;
            rep_k   = 0;
`endif
        end else begin
            for (int b = 0; b < NB; b++) begin
                ev[b]   = lvh[b][1] & ~lvh[b][2];
                held[b] = lvh[b][1];
            end
            e_rst = ev[4];
            e_up  = ev[0] && !ev[1];
            e_dn  = ev[1] && !ev[0];
            if (ev[4]) cur_idx = 0;
            else if (ev[2] && !ev[3]) cur_idx = (cur_idx + 1) % 3;
            else if (ev[3] && !ev[2]) cur_idx = (cur_idx + 2) % 3;
`ifdef BUTTON_AUTO_REPEAT_EN
            if (!rep_act) begin
                if (e_up || e_dn) begin
                    rep_act    = 1'b1;
                    rep_key_up = e_up;
                    rep_k      = 0;
                end
            end else begin
                cancel = ev[4] || (rep_key_up ? (!held[0] || ev[1]) : (!held[1] || ev[0]));
                if (cancel) begin
                    rep_act = 1'b0;
                end else begin
                    rep_k++;
                    if (rep_k == RD || (rep_k > RD && (rep_k - RD) % RP == 0)) begin
                        if (rep_key_up) e_up = 1'b1;
                        else            e_dn = 1'b1;
                    end
                end
            end
`endif
            for (int b = 0; b < NB; b++) begin
                eff = !smp[b][1];
                smp[b][1] = smp[b][0];
                smp[b][0] = in_b[b];
                if (eff == lvl[b]) begin
                    run[b] = 0;
                end else begin
                    run[b]++;
                    if (run[b] == D) begin
                        lvl[b] = !lvl[b];
                        run[b] = 0;
                    end
                end
                lvh[b] = {lvh[b][1:0], lvl[b]};
            end
        end
        e_cur = 3'b001 << cur_idx;
        #1;
        chk("up", 32'(up), 32'(e_up));
        chk("down", 32'(down), 32'(e_dn));
        chk("clock_reset", 32'(clock_reset), 32'(e_rst));
        chk("cursor_pos", 32'(cursor_pos), 32'(e_cur));
        if (up === 1'b1)          up_edges.push_back(cyc);
        if (down === 1'b1)        dn_edges.push_back(cyc);
        if (clock_reset === 1'b1) rst_edges.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input int b, input int hold, input int gap);
        btn_n[b] = 1'b0;
        step(hold);
        btn_n[b] = 1'b1;
        step(gap);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(2);
    endtask

    int base_u, base_d, base_r, e0, r0, nsz, seg_len, sel;
    logic [4:0] target, v;
    logic [2:0] exp_cur [3];

    initial begin
        step(3);
        reset = 1'b0;
        step(2);
        chk("reset_up", 32'(up), 32'd0);
        chk("reset_down", 32'(down), 32'd0);
        chk("reset_clock_reset", 32'(clock_reset), 32'd0);
        chk("reset_cursor", 32'(cursor_pos), 32'd1);

        // Single held press: one pulse 7 edges after the first sampling edge.
        base_u = up_edges.size(); base_d = dn_edges.size(); e0 = cyc;
        press(0, 30, 15);
`ifdef BUTTON_AUTO_REPEAT_EN
        chk("single_press_count", 32'(up_edges.size() - base_u), 32'd3);
`else
        chk("single_press_count", 32'(up_edges.size() - base_u), 32'd1);
`endif
        chk("single_press_latency", (up_edges.size() > base_u) ? 32'(up_edges[base_u] - (e0 + 1)) : 32'hFFFF_FFFF, 32'd7);
        chk("single_press_no_down", 32'(dn_edges.size() - base_d), 32'd0);

        // Bouncing down button never settles long enough.
        base_d = dn_edges.size();
        for (int i = 0; i < 10; i++) begin
            btn_n[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(2);
        end
        btn_n[1] = 1'b1;
        step(12);
        chk("bounce_no_down", 32'(dn_edges.size() - base_d), 32'd0);

        // Cursor rotation and clock reset.
        do_reset();
        exp_cur[0] = 3'b010; exp_cur[1] = 3'b100; exp_cur[2] = 3'b001;
        for (int i = 0; i < 3; i++) begin
            press(2, 10, 10);
            chk("cursor_left", 32'(cursor_pos), 32'(exp_cur[i]));
        end
        press(3, 10, 10);
        chk("cursor_right", 32'(cursor_pos), 32'd4);
        base_r = rst_edges.size();
        press(4, 10, 10);
        chk("clock_reset_count", 32'(rst_edges.size() - base_r), 32'd1);
        chk("cursor_after_rst", 32'(cursor_pos), 32'd1);

`ifdef BUTTON_AUTO_REPEAT_EN
        // Auto-repeat: first pulse, then +RD, then every RP until release.
        base_u = up_edges.size(); e0 = cyc;
        press(0, 60, 20);
        nsz = up_edges.size() - base_u;
        chk("repeat_count", 32'(nsz), 32'd9);
        for (int i = 0; i < 9; i++) begin
            chk("repeat_time", (i < nsz) ? 32'(up_edges[base_u + i] - e0) : 32'hFFFF_FFFF,
                (i == 0) ? 32'd8 : 32'(28 + 5 * (i - 1)));
        end
`endif

        // Up and down in the same cycle: no pulse and no repeat.
        base_u = up_edges.size(); base_d = dn_edges.size();
        btn_n[1:0] = 2'b00;
        step(40);
        btn_n[1:0] = 2'b11;
        step(15);
        chk("both_no_up", 32'(up_edges.size() - base_u), 32'd0);
        chk("both_no_down", 32'(dn_edges.size() - base_d), 32'd0);

        // Reset during a held press, released while still held.
        base_u = up_edges.size();
        btn_n[0] = 1'b0;
        step(2);
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        r0 = cyc;
        step(15);
        btn_n[0] = 1'b1;
        step(15);
        chk("reset_abort_count", 32'(up_edges.size() - base_u), 32'd1);
        chk("reset_abort_latency", (up_edges.size() > base_u) ? 32'(up_edges[base_u] - (r0 + 1)) : 32'hFFFF_FFFF, 32'd7);

        // Randomized activity against the model.
        for (int seg = 0; seg < 120; seg++) begin
            sel = $urandom_range(0, 9);
            target = 5'b11111;
            if (sel < 5) target[sel] = 1'b0;
            else if (sel == 5) target[1:0] = 2'b00;
            else if (sel == 6) target[3:2] = 2'b00;
            else if (sel == 7) target = 5'($urandom_range(0, 31));
            if (sel == 9) begin
                reset = 1'b1;
                step($urandom_range(1, 3));
                reset = 1'b0;
            end else begin
                seg_len = $urandom_range(1, 30);
                if ($urandom_range(0, 7) == 0) seg_len = $urandom_range(40, 70);
                for (int i = 0; i < seg_len; i++) begin
                    v = target;
                    if ($urandom_range(0, 9) == 0) v[$urandom_range(0, 4)] ^= 1'b1;
                    btn_n = v;
                    step(1);
                end
            end
        end
        btn_n = 5'b11111;
        step(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
